// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared definitions for the data cache and store buffer
package dcache_pkg;

    localparam int SB_NUM_ENTRIES = 4;
    localparam int DC_NUM_LINES   = 4;
    localparam int DC_LINE_BITS   = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVICT = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_WORD = 2'd1,
        WR_BYTE = 2'd2,
        WR_LINE = 2'd3
    } wr_kind_t;

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag/valid/dirty/data storage, combinational read, synchronous write
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DC_NUM_LINES,
    parameter int LINE_BITS = DC_LINE_BITS,
    parameter int IDX_BITS  = $clog2(DC_NUM_LINES),
    parameter int TAG_BITS  = 28 - $clog2(DC_NUM_LINES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_BITS-1:0]  rd_index,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_BITS-1:0]  rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  wr_kind_t             wr_kind,
    input  logic [IDX_BITS-1:0]  wr_index,
    input  logic [1:0]           wr_word,
    input  logic [1:0]           wr_offset,
    input  logic [31:0]          wr_data,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [LINE_BITS-1:0] wr_line
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_kind == WR_LINE) begin
            valid_q[wr_index] <= 1'b1;
            dirty_q[wr_index] <= 1'b0;
        end else if (wr_kind != WR_NONE) begin
            dirty_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage are deliberately left out of reset; valid gates them.
    always_ff @(posedge clk) begin
        if (wr_kind == WR_LINE) begin
            data_q[wr_index] <= wr_line;
            tag_q[wr_index]  <= wr_tag;
        end else if (wr_kind == WR_WORD) begin
            data_q[wr_index][{wr_word, 5'b0} +: 32] <= wr_data;
        end else if (wr_kind == WR_BYTE) begin
            data_q[wr_index][{wr_word, wr_offset, 3'b0} +: 8] <= wr_data[7:0];
        end
    end

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-back data cache with IDLE/EVICT/FILL miss FSM
module dcache
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DC_NUM_LINES,
    parameter int LINE_BITS = DC_LINE_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_load,
    input  logic                 req_store,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic                 is_byte,
    output logic [31:0]          rdata,
    output logic                 stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic [LINE_BITS-1:0] mem_rdata
);

    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS = 28 - IDX_BITS;

    state_t                state, state_next;
    logic [27:0]           miss_line;
    logic [IDX_BITS-1:0]   addr_idx, miss_idx, rd_index, wr_index;
    logic [TAG_BITS-1:0]   addr_tag, miss_tag, rd_tag;
    logic                  rd_valid, rd_dirty;
    logic [LINE_BITS-1:0]  rd_line;
    wr_kind_t              wr_kind;
    logic                  active, hit;
    logic [31:0]           hit_word;

    assign addr_idx = addr[4 +: IDX_BITS];
    assign addr_tag = addr[31 -: TAG_BITS];
    assign miss_idx = miss_line[IDX_BITS-1:0];
    assign miss_tag = miss_line[27 -: TAG_BITS];

    // Once a miss is in flight the array is addressed only by the latched line.
    assign rd_index = (state == ST_IDLE) ? addr_idx : miss_idx;

    assign active   = req_load | req_store;
    assign hit      = (state == ST_IDLE) && rd_valid && (rd_tag == addr_tag);
    assign stall    = (active && !hit) || (state != ST_IDLE) || (req_load && req_store);
    assign hit_word = rd_line[{addr[3:2], 5'b0} +: 32];

    always_comb begin
        rdata = '0;
        if (req_load && hit) begin
            rdata = is_byte ? {24'b0, hit_word[{addr[1:0], 3'b0} +: 8]} : hit_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && active && !hit) begin
            miss_line <= addr[31:4];
        end
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            ST_IDLE: begin
                if (active && !hit) begin
                    state_next = (rd_valid && rd_dirty) ? ST_EVICT : ST_FILL;
                end
            end
            ST_EVICT: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {rd_tag, miss_idx, 4'b0};
                mem_wdata = rd_line;
                if (mem_ready) state_next = ST_FILL;
            end
            ST_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {miss_tag, miss_idx, 4'b0};
                if (mem_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A store shares the cycle with a load only by waiting; the load wins.
    always_comb begin
        wr_kind  = WR_NONE;
        wr_index = addr_idx;
        if (state == ST_FILL && mem_ready) begin
            wr_kind  = WR_LINE;
            wr_index = miss_idx;
        end else if (req_store && !req_load && hit) begin
            wr_kind = is_byte ? WR_BYTE : WR_WORD;
        end
    end

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LINE_BITS),
        .IDX_BITS  (IDX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .rd_index  (rd_index),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .wr_kind   (wr_kind),
        .wr_index  (wr_index),
        .wr_word   (addr[3:2]),
        .wr_offset (addr[1:0]),
        .wr_data   (wdata),
        .wr_tag    (miss_tag),
        .wr_line   (mem_rdata)
    );

endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - directed self-checking bench for dcache
module tb_dcache;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_load, req_store, is_byte;
    logic [31:0]  addr, wdata, rdata, mem_addr;
    logic         stall, mem_req, mem_we, mem_ready;
    logic [127:0] mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dcache dut (
        .clk       (clk),
        .reset     (reset),
        .req_load  (req_load),
        .req_store (req_store),
        .addr      (addr),
        .wdata     (wdata),
        .is_byte   (is_byte),
        .rdata     (rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    task automatic drive(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] wd, input logic byt);
        @(negedge clk);
        req_load  = ld;
        req_store = st;
        addr      = a;
        wdata     = wd;
        is_byte   = byt;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_load = 0; req_store = 0; addr = 0; wdata = 0; is_byte = 0;
        mem_ready = 0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %0b want 0", stall); end
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        vectors++; if ({mem_req, mem_we} !== 2'b00) begin miscompares++; $display("FAIL reset_mem_req_we: got %b want 00", {mem_req, mem_we}); end
        vectors++; if (mem_addr !== 32'h0 || mem_wdata !== 128'h0) begin miscompares++; $display("FAIL reset_mem_bus: addr %h wdata %h want 0", mem_addr, mem_wdata); end
    endtask

    task automatic test_cold_load;
        drive(1, 0, 32'h100, 0, 0);
        vectors++; if (stall !== 1'b1 || mem_req !== 1'b0) begin miscompares++; $display("FAIL cold_miss_idle: stall %0b mem_req %0b want 1 0", stall, mem_req); end
        @(negedge clk); #1;
        vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin miscompares++; $display("FAIL cold_fill: req %0b we %0b addr %h want 1 0 00000100", mem_req, mem_we, mem_addr); end
        @(negedge clk); #1;
        vectors++; if (stall !== 1'b1 || mem_req !== 1'b1) begin miscompares++; $display("FAIL cold_wait: stall %0b mem_req %0b want 1 1", stall, mem_req); end
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        vectors++; if (stall !== 1'b0 || rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL cold_replay: stall %0b rdata %h want 0 deadbeef", stall, rdata); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL cold_mem_idle: mem_req %0b want 0", mem_req); end
        drive(1, 0, 32'h103, 0, 1);
        vectors++; if (rdata !== 32'h000000DE) begin miscompares++; $display("FAIL byte_load: got %h want 000000de", rdata); end
        drive(1, 0, 32'h10B, 0, 0);
        vectors++; if (rdata !== 32'h22222222) begin miscompares++; $display("FAIL word_ignores_offset: got %h want 22222222", rdata); end
    endtask

    task automatic test_byte_store;
        drive(0, 1, 32'h101, 32'h000000AA, 1);
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL store_hit_stall: got %0b want 0", stall); end
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL store_rdata_zero: got %h want 0", rdata); end
        drive(1, 0, 32'h100, 0, 0);
        vectors++; if (rdata !== 32'hDEADAAEF) begin miscompares++; $display("FAIL byte_store_result: got %h want deadaaef", rdata); end
    endtask

    task automatic test_load_store_same_cycle;
        drive(1, 1, 32'h104, 32'h55555555, 0);
        vectors++; if (rdata !== 32'h11111111) begin miscompares++; $display("FAIL both_load_data: got %h want 11111111", rdata); end
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL both_store_stall: got %0b want 1", stall); end
        drive(0, 1, 32'h108, 32'h12345678, 0);
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL store_next_cycle: stall %0b want 0", stall); end
        drive(1, 0, 32'h104, 0, 0);
        vectors++; if (rdata !== 32'h11111111) begin miscompares++; $display("FAIL stalled_store_no_write: got %h want 11111111", rdata); end
        drive(1, 0, 32'h108, 0, 0);
        vectors++; if (rdata !== 32'h12345678) begin miscompares++; $display("FAIL store_word_result: got %h want 12345678", rdata); end
    endtask

    task automatic test_dirty_evict;
        drive(1, 0, 32'h140, 0, 0);
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL evict_miss_stall: got %0b want 1", stall); end
        @(negedge clk); #1;
        vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100) begin miscompares++; $display("FAIL evict_cmd: req %0b we %0b addr %h want 1 1 00000100", mem_req, mem_we, mem_addr); end
        vectors++; if (mem_wdata[31:0] !== 32'hDEADAAEF || mem_wdata[95:64] !== 32'h12345678) begin miscompares++; $display("FAIL evict_data: got %h", mem_wdata); end
        mem_ready = 1'b1;
        mem_rdata = {32'h0, 32'h0, 32'h0, 32'hCAFE0140};
        @(negedge clk); #1;
        vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h140) begin miscompares++; $display("FAIL evict_then_fill: req %0b we %0b addr %h want 1 0 00000140", mem_req, mem_we, mem_addr); end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        vectors++; if (stall !== 1'b0 || rdata !== 32'hCAFE0140) begin miscompares++; $display("FAIL evict_replay: stall %0b rdata %h want 0 cafe0140", stall, rdata); end
    endtask

    task automatic test_clean_miss;
        drive(1, 0, 32'h200, 0, 0);
        @(negedge clk); #1;
        vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h200) begin miscompares++; $display("FAIL clean_direct_fill: req %0b we %0b addr %h want 1 0 00000200", mem_req, mem_we, mem_addr); end
        mem_ready = 1'b1;
        mem_rdata = {32'h0, 32'h0, 32'h0, 32'h0200AAAA};
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        vectors++; if (stall !== 1'b0 || rdata !== 32'h0200AAAA) begin miscompares++; $display("FAIL clean_replay: stall %0b rdata %h want 0 0200aaaa", stall, rdata); end
    endtask

    task automatic test_index_wrap;
        drive(1, 0, 32'h130, 0, 0);
        @(negedge clk); #1;
        vectors++; if (mem_addr !== 32'h130 || mem_we !== 1'b0) begin miscompares++; $display("FAIL wrap_fill: addr %h we %0b want 00000130 0", mem_addr, mem_we); end
        mem_ready = 1'b1;
        mem_rdata = {32'h0, 32'h0, 32'h0, 32'h33330130};
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        vectors++; if (rdata !== 32'h33330130) begin miscompares++; $display("FAIL wrap_high_line: got %h want 33330130", rdata); end
        drive(1, 0, 32'h200, 0, 0);
        vectors++; if (stall !== 1'b0 || rdata !== 32'h0200AAAA) begin miscompares++; $display("FAIL wrap_low_line: stall %0b rdata %h want 0 0200aaaa", stall, rdata); end
    endtask

    task automatic test_reset_mid_fill;
        drive(1, 0, 32'h100, 0, 0);
        @(negedge clk); #1;
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin miscompares++; $display("FAIL rst_fill_entry: req %0b addr %h want 1 00000100", mem_req, mem_addr); end
        @(negedge clk);
        reset = 1'b1;
        req_load = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b0 || stall !== 1'b0) begin miscompares++; $display("FAIL rst_abandon: mem_req %0b stall %0b want 0 0", mem_req, stall); end
        drive(1, 0, 32'h100, 0, 0);
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL rst_remiss: stall %0b want 1", stall); end
        @(negedge clk); #1;
        vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin miscompares++; $display("FAIL rst_refill: req %0b we %0b addr %h want 1 0 00000100", mem_req, mem_we, mem_addr); end
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_byte_store();
        test_load_store_same_cycle();
        test_dirty_evict();
        test_clean_miss();
        test_index_wrap();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameter NUM_LINES, default 4, number of direct-mapped lines (power of two, at least 2).
REQ-002 Parameter LINE_BITS, default 128, line size in bits (four 32-bit words).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_load  input  1  load lookup request from the memory stage.
REQ-006 req_store  input  1  store request from the store buffer drain (drain_out and is_data_to_cache).
REQ-007 addr  input  32  byte address of the access.
REQ-008 wdata  input  32  store data; for byte stores only bits 7:0 are used.
REQ-009 is_byte  input  1  1 = byte access, 0 = word access.
REQ-010 rdata  output  32  load data: the word, or the byte zero-extended.
REQ-011 stall  output  1  request not complete; this drives the store buffer's stall_dcache input.
REQ-012 mem_req  output  1  memory transaction valid.
REQ-013 mem_we  output  1  1 = writeback, 0 = line fill.
REQ-014 mem_addr  output  32  line-aligned address (bits 3:0 = 0).
REQ-015 mem_wdata  output  LINE_BITS  victim line data.
REQ-016 mem_ready  input  1  memory accepts or completes the transaction this cycle.
REQ-017 mem_rdata  input  LINE_BITS  fill data, valid when mem_ready=1 in the FILL state.

Function
REQ-018 Address fields: offset = addr[1:0], word = addr[3:2], index = addr[4+log2(NUM_LINES)-1:4], tag = remaining upper bits.
REQ-019 Hit: state is IDLE, the indexed line is valid, and the stored tag equals the address tag.
REQ-020 Active request: req_load OR req_store; if both are asserted, the load is serviced and the store stays stalled.
REQ-021 stall = active request AND NOT hit, or state != IDLE; stall is combinational.
REQ-022 Load hit: rdata is combinational in the same cycle; a byte load returns {24'b0, byte[offset]}.
REQ-023 rdata = 0 when no load hit is in progress.
REQ-024 Store hit: on the next edge, update the word, or only byte[offset] for a byte store, and set the line's dirty bit.
REQ-025 Store hit latency: 0 stall cycles.
REQ-026 Word accesses ignore addr[1:0].
REQ-027 The FSM has three states: IDLE, EVICT and FILL.
REQ-028 IDLE with an active miss: go to EVICT if the victim line is valid and dirty, otherwise go to FILL.
REQ-029 On the IDLE-to-miss transition, latch the miss address; EVICT and FILL use only the latched value.
REQ-030 EVICT: mem_req=1, mem_we=1, mem_addr = {victim tag, index, 4'b0}, mem_wdata = victim line; on mem_ready go to FILL.
REQ-031 FILL: mem_req=1, mem_we=0, mem_addr = {latched tag, index, 4'b0}.
REQ-032 On mem_ready in FILL: write the line from mem_rdata, set valid=1, dirty=0, store the tag, and go to IDLE.
REQ-033 After FILL the request replays in IDLE and hits, so the total miss penalty is the memory latency plus 1 cycle.
REQ-034 The requester holds addr, wdata, is_byte and its request high while stall=1; the cache does not require request changes to be observed mid-miss.
REQ-035 Outside EVICT and FILL: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-036 mem_ready is ignored in IDLE.
REQ-037 Index wrap: the highest index and index 0 are independent lines with no aliasing.

Reset
REQ-038 Reset clears every valid and dirty bit and forces state to IDLE.
REQ-039 Reset mid-EVICT or mid-FILL abandons the transaction, with mem_req=0 on the following cycle.
REQ-040 After reset: stall=0 when idle, rdata=0, and all mem_* outputs = 0.
REQ-041 The data and tag arrays are not reset.

Structure
REQ-042 The FSM state encodings and the NUM_LINES/LINE_BITS defaults are defines in the shared definitions file, next to SB_NUM_ENTRIES.
REQ-043 One sub-module, dcache_array, holds the tag, valid, dirty and data storage with a combinational read and a synchronous word/byte/line write; the FSM and datapath live in dcache.

Verification
REQ-044 Cold load: after reset, req_load at addr 0x100 -> stall=1, FILL with mem_addr=0x100; mem_ready after 3 cycles with mem_rdata word0=0xDEADBEEF -> next cycle stall=0 and rdata=0xDEADBEEF.
REQ-045 Byte store hit: line 0x100 resident, req_store at 0x101 with is_byte=1 and wdata=0xAA -> no stall; a following word load at 0x100 returns 0xDEADAAEF.
REQ-046 Dirty eviction: store to 0x100, then load 0x140 (same index, NUM_LINES=4) -> EVICT with mem_we=1, mem_addr=0x100 and mem_wdata word0=0xDEADAAEF, then FILL at 0x140.
REQ-047 Simultaneous load and store hits at different words -> the load returns data in that cycle, the store shows stall=1 and completes in the next cycle.
REQ-048 Reset asserted during FILL with mem_ready held at 0 -> the next cycle has mem_req=0 and state IDLE; a load to 0x100 then misses again.
REQ-049 Clean miss: load at 0x200 whose victim is valid but clean -> goes directly to FILL with no EVICT cycle.
